// File: rtl/ps2_pkg.sv
// Shared scan-code constants, key bitmap indices and decoder FSM states
// for the PS/2 keyboard controller.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK   = 8'hF0;
    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_A       = 8'h1C;
    localparam logic [7:0] SC_D       = 8'h23;
    localparam logic [7:0] SC_SPACE   = 8'h29;
    localparam logic [7:0] SC_W       = 8'h1D;
    localparam logic [7:0] SC_S       = 8'h1B;
    localparam logic [7:0] SC_ESC     = 8'h76;
    localparam logic [7:0] SC_ENTER   = 8'h5A;
    localparam logic [7:0] SC_X_LEFT  = 8'h6B;
    localparam logic [7:0] SC_X_DOWN  = 8'h72;
    localparam logic [7:0] SC_X_RIGHT = 8'h74;
    localparam logic [7:0] SC_X_UP    = 8'h75;

    localparam int KB_LEFT    = 0;
    localparam int KB_RIGHT   = 1;
    localparam int KB_SHOOT   = 2;
    localparam int KB_UP      = 3;
    localparam int KB_DOWN    = 4;
    localparam int KB_ESC     = 5;
    localparam int KB_ENTER   = 6;
    localparam int KB_X_LEFT  = 8;
    localparam int KB_X_DOWN  = 9;
    localparam int KB_X_RIGHT = 10;
    localparam int KB_X_UP    = 11;

    localparam int EVT_MAKE_BIT = 15;
    localparam int EVT_EXT_BIT  = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DECODE
    } ps2_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } key_map_t;

    // Scan code (plus E0 prefix flag) to held-key bitmap position.
    function automatic key_map_t key_map(input logic [7:0] code, input logic ext);
        key_map = '{hit: 1'b1, idx: 4'd0};
        if (!ext) begin
            case (code)
                SC_A:     key_map.idx = 4'(KB_LEFT);
                SC_D:     key_map.idx = 4'(KB_RIGHT);
                SC_SPACE: key_map.idx = 4'(KB_SHOOT);
                SC_W:     key_map.idx = 4'(KB_UP);
                SC_S:     key_map.idx = 4'(KB_DOWN);
                SC_ESC:   key_map.idx = 4'(KB_ESC);
                SC_ENTER: key_map.idx = 4'(KB_ENTER);
                default:  key_map.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_X_LEFT:  key_map.idx = 4'(KB_X_LEFT);
                SC_X_RIGHT: key_map.idx = 4'(KB_X_RIGHT);
                SC_X_UP:    key_map.idx = 4'(KB_X_UP);
                SC_X_DOWN:  key_map.idx = 4'(KB_X_DOWN);
                default:    key_map.hit = 1'b0;
            endcase
        end
    endfunction

endpackage

// File: rtl/ps2_key_controller_if.sv
// Key event stream handshake between the PS/2 controller and its consumer.
interface ps2_key_controller_if;
    logic        evt_valid;
    logic        evt_ready;
    logic [15:0] evt_data;

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/ps2_evt_fifo.sv
// Small synchronous FIFO for decoded key events; dout shows the head entry.
module ps2_evt_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_key_controller.sv
// PS/2 keyboard receiver, make/break decoder and held-key bitmap in the clk domain.
// Define PS2_EXT_KEYS_EN to decode the E0 prefix and drive key_state bits 8-11.
module ps2_key_controller
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int TIMEOUT_US = 1000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ps2_clk,
    input  logic                   ps2_data,
    ps2_key_controller_if.master   evt,
    output logic [15:0]            key_state,
    output logic                   frame_err,
    output logic [7:0]             err_count
);
    localparam int TIMEOUT_CYCLES = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]      clk_s, dat_s;
    logic            clk_prev;
    logic            fall, sdat;

    ps2_state_e      state;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            par_ok;
    logic [TO_W-1:0] tcnt;
    logic            brk_q, ext_q;

    logic            in_frame, timeout, err_now;
    logic            is_prefix, evt_push, evt_pop, drop;
    logic            fifo_full, fifo_empty;
    logic [15:0]     fifo_dout, evt_din;
    key_map_t        km;

    // Idle-high reset values so release never fakes a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s    <= 2'b11;
            dat_s    <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_s    <= {clk_s[0], ps2_clk};
            dat_s    <= {dat_s[0], ps2_data};
            clk_prev <= clk_s[1];
        end
    end

    assign fall = clk_prev && !clk_s[1];
    assign sdat = dat_s[1];

    assign in_frame = (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP);
    assign timeout  = in_frame && !fall && (tcnt >= TO_W'(TIMEOUT_CYCLES));

    always_comb begin
        err_now = timeout;
        if (fall && (state == ST_IDLE) && sdat)               err_now = 1'b1;
        if (fall && (state == ST_STOP) && !(sdat && par_ok))  err_now = 1'b1;
    end

`ifdef PS2_EXT_KEYS_EN
    assign is_prefix = (shift == SC_BREAK) || (shift == SC_EXT);
`else
    assign is_prefix = (shift == SC_BREAK);
`endif

    assign km       = key_map(shift, ext_q);
    assign evt_push = (state == ST_DECODE) && !is_prefix;
    assign evt_pop  = evt.evt_valid && evt.evt_ready;
    assign drop     = evt_push && fifo_full && !evt_pop;
    assign evt_din  = {~brk_q, ext_q, 6'b0, shift};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bit_idx   <= '0;
            shift     <= '0;
            par_ok    <= 1'b0;
            tcnt      <= '0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            key_state <= '0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            frame_err <= err_now;
            if ((err_now || drop) && (err_count != 8'hFF)) err_count <= err_count + 8'd1;

            if (!in_frame || fall) tcnt <= '0;
            else if (!timeout)     tcnt <= tcnt + TO_W'(1);

            case (state)
                ST_IDLE: begin
                    if (fall && !sdat) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (fall) begin
                        shift   <= {sdat, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= ST_PARITY;
                    end else if (timeout) begin
                        state <= ST_IDLE;
                    end
                end
                ST_PARITY: begin
                    if (fall) begin
                        par_ok <= ^{shift, sdat};
                        state  <= ST_STOP;
                    end else if (timeout) begin
                        state <= ST_IDLE;
                    end
                end
                ST_STOP: begin
                    if (fall) state <= (sdat && par_ok) ? ST_DECODE : ST_IDLE;
                    else if (timeout) state <= ST_IDLE;
                end
                ST_DECODE: begin
                    state <= ST_IDLE;
                    if (shift == SC_BREAK) begin
                        brk_q <= 1'b1;
`ifdef PS2_EXT_KEYS_EN
                    end else if (shift == SC_EXT) begin
                        ext_q <= 1'b1;
`endif
                    end else begin
                        brk_q <= 1'b0;
                        ext_q <= 1'b0;
                        // A dropped event still updates the bitmap.
                        if (km.hit) key_state[km.idx] <= ~brk_q;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ps2_evt_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (evt_push),
        .pop   (evt_pop),
        .din   (evt_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt.evt_valid = !fifo_empty;
    assign evt.evt_data  = fifo_empty ? 16'h0000 : fifo_dout;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Scoreboard bench for ps2_key_controller; 2 MHz clock keeps the timeout at 2000 cycles.
`timescale 1ns/1ps
module tb_ps2_key_controller;
    localparam int CLK_HZ   = 2000000;
    localparam int HALF_BIT = 40;    // 20 us half PS/2 period at 2 MHz
    localparam int GAP      = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key_state;
    logic        frame_err;
    logic [7:0]  err_count;

    ps2_key_controller_if evt_if();

    ps2_key_controller #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(1000), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .evt       (evt_if.master),
        .key_state (key_state),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    always #250 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          fe_cnt = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Every wait goes through tick so the scoreboard sees each handshake.
    task automatic tick();
        @(negedge clk);
        if (frame_err) fe_cnt++;
        if (evt_if.evt_valid && evt_if.evt_ready) begin
            if (exp_q.size() != 0) chk("evt", evt_if.evt_data, exp_q.pop_front());
            else chk("evt_unexpected", 16'd1, 16'(exp_q.size()));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 evt_if.evt_ready = r;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        ticks(HALF_BIT);
        ps2_clk = 1'b0;
        ticks(HALF_BIT);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit((~^code) ^ bad_par);
        send_bit(1'b1);
        ps2_data = 1'b1;
        ticks(GAP);
    endtask

    task automatic send_partial(input logic [7:0] code);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(code[i]);
        ps2_data = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ticks(4);
        reset = 1'b1;
        ticks(4);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        chk(tag, 16'(exp_q.size()), 16'd0);
    endtask

    int fe0;

    initial begin
        evt_if.evt_ready = 1'b1;
        ticks(3);
        chk("rst_valid", {15'd0, evt_if.evt_valid}, 16'd0);
        chk("rst_data", evt_if.evt_data, 16'h0000);
        chk("rst_keys", key_state, 16'h0000);
        chk("rst_ferr", {15'd0, frame_err}, 16'd0);
        chk("rst_errcnt", {8'd0, err_count}, 16'd0);
        reset = 1'b1;
        ticks(4);

        // make then break of A
        exp_q.push_back(16'h801C);
        send_frame(8'h1C, 1'b0);
        chk("t1_key_make", key_state, 16'h0001);
        exp_q.push_back(16'h001C);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        chk("t1_key_break", key_state, 16'h0000);
        drain("t1_pending");

        // bad parity
        do_reset();
        fe0 = fe_cnt;
        send_frame(8'h29, 1'b1);
        chk("t2_fe_pulses", 16'(fe_cnt - fe0), 16'd1);
        chk("t2_errcnt", {8'd0, err_count}, 16'd1);
        chk("t2_valid", {15'd0, evt_if.evt_valid}, 16'd0);
        chk("t2_keys", key_state, 16'h0000);

        // timeout mid-frame, then a clean frame
        do_reset();
        fe0 = fe_cnt;
        send_partial(8'h23);
        ticks(2400);
        chk("t3_fe_pulses", 16'(fe_cnt - fe0), 16'd1);
        chk("t3_errcnt", {8'd0, err_count}, 16'd1);
        exp_q.push_back(16'h8023);
        send_frame(8'h23, 1'b0);
        drain("t3_pending");
        chk("t3_keys", key_state, 16'h0002);

        // overflow: 6 makes into a depth-4 queue
        do_reset();
        set_ready(1'b0);
        fe0 = fe_cnt;
        exp_q.push_back(16'h801C);
        exp_q.push_back(16'h8023);
        exp_q.push_back(16'h8029);
        exp_q.push_back(16'h801D);
        send_frame(8'h1C, 1'b0);
        send_frame(8'h23, 1'b0);
        send_frame(8'h29, 1'b0);
        send_frame(8'h1D, 1'b0);
        send_frame(8'h1B, 1'b0);
        send_frame(8'h76, 1'b0);
        chk("t4_valid", {15'd0, evt_if.evt_valid}, 16'd1);
        chk("t4_head", evt_if.evt_data, 16'h801C);
        chk("t4_errcnt", {8'd0, err_count}, 16'd2);
        chk("t4_fe_pulses", 16'(fe_cnt - fe0), 16'd0);
        chk("t4_keys", key_state, 16'h003F);
        set_ready(1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_burst_vld", {15'd0, evt_if.evt_valid}, 16'd1);
        end
        tick();
        chk("t4_burst_end", {15'd0, evt_if.evt_valid}, 16'd0);
        chk("t4_pending", 16'(exp_q.size()), 16'd0);

        // extended keys
        do_reset();
`ifdef PS2_EXT_KEYS_EN
        exp_q.push_back(16'hC06B);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h6B, 1'b0);
        chk("t5_key_xmake", key_state, 16'h0100);
        exp_q.push_back(16'h406B);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h6B, 1'b0);
        chk("t5_key_xbreak", key_state, 16'h0000);
`else
        exp_q.push_back(16'h80E0);
        exp_q.push_back(16'h806B);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h6B, 1'b0);
        chk("t5_key_plain", key_state, 16'h0000);
        exp_q.push_back(16'h80E0);
        exp_q.push_back(16'h006B);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h6B, 1'b0);
        chk("t5_key_plain2", key_state, 16'h0000);
`endif
        drain("t5_pending");

        // reset mid-frame with state held
        do_reset();
        set_ready(1'b0);
        send_frame(8'h1C, 1'b0);
        chk("t6_pre_valid", {15'd0, evt_if.evt_valid}, 16'd1);
        send_partial(8'h1C);
        reset = 1'b0;
        #1;
        chk("t6_valid", {15'd0, evt_if.evt_valid}, 16'd0);
        chk("t6_data", evt_if.evt_data, 16'h0000);
        chk("t6_keys", key_state, 16'h0000);
        chk("t6_errcnt", {8'd0, err_count}, 16'd0);
        chk("t6_ferr", {15'd0, frame_err}, 16'd0);
        ticks(4);
        reset = 1'b1;
        ticks(4);
        set_ready(1'b1);
        exp_q.push_back(16'h801C);
        send_frame(8'h1C, 1'b0);
        drain("t6_pending");
        chk("t6_keys_after", key_state, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
